// File: rtl/nsr_vec_seq.sv
// Vector access sequencer for the 32-entry neuron state register file.
// Expands one VL=1/4/16 request into single-element NSR reads or writes, one per handshake beat.
module nsr_vec_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_vl,
  input  logic [ADDR_W-1:0] req_base,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              nsr_we,
  output logic [ADDR_W-1:0] nsr_wa,
  output logic [DATA_W-1:0] nsr_wd,
  output logic [ADDR_W-1:0] nsr_ra,
  input  logic [DATA_W-1:0] nsr_rd,
  output logic              busy,
  output logic              done,
  output logic              err_vl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        idx_r;
  logic [ADDR_W-1:0] base_r;
  logic [4:0]        len_r;
  logic              done_r;
  logic              err_vl_r;

  logic [ADDR_W-1:0] addr_s;
  logic              beat_s;
  logic              last_s;

  // Element count for a VL code; the reserved code maps to zero elements.
  function automatic logic [4:0] vl_len(input logic [1:0] vl);
    logic [4:0] len;
    case (vl)
      2'b00:   len = 5'd1;
      2'b01:   len = 5'd4;
      2'b10:   len = 5'd16;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

  // Element address, handshake beat and last-beat detection.
  always_comb begin
    addr_s = base_r + ADDR_W'(idx_r);
    beat_s = 1'b0;
    if (state_r == WR) begin
      beat_s = wdata_valid;
    end else if (state_r == RD) begin
      beat_s = rdata_ready;
    end else begin
      beat_s = 1'b0;
    end
    last_s = ({1'b0, idx_r} == (len_r - 5'd1));
  end

  // Handshake and NSR port are combinational from state so elements move with zero added latency.
  assign req_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign wdata_ready = (state_r == WR);
  assign rdata_valid = (state_r == RD);
  assign rdata       = nsr_rd;
  assign nsr_we      = (state_r == WR) && wdata_valid;
  assign nsr_wa      = addr_s;
  assign nsr_wd      = wdata;
  assign nsr_ra      = addr_s;
  assign done        = done_r;
  assign err_vl      = err_vl_r;

  // Sequencer state, element counter and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      idx_r    <= 4'd0;
      base_r   <= '0;
      len_r    <= 5'd0;
      done_r   <= 1'b0;
      err_vl_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      err_vl_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            base_r <= req_base;
            len_r  <= vl_len(req_vl);
            idx_r  <= 4'd0;
            // Reserved VL is consumed without touching the NSR.
            if (req_vl == 2'b11) begin
              err_vl_r <= 1'b1;
            end else if (req_wr) begin
              state_r <= WR;
            end else begin
              state_r <= RD;
            end
          end
        end
        WR, RD: begin
          if (beat_s) begin
            idx_r <= idx_r + 4'd1;
            if (last_s) begin
              state_r <= IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
